// File: rtl/lab_ms_alu_seq.sv
// Sequential unsigned ALU (ADD/SUB/MUL/DIV/VAR) with valid/ready handshakes and an iterative
// restoring divider. Define ALU_SAT_EN to make ADD/SUB saturate instead of wrapping.
module lab_ms_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_opc,
  input  logic [WIDTH-1:0]   in_op_a,
  input  logic [WIDTH-1:0]   in_op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_err,
  output logic               out_ovf,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpDiv = 3'd3;
  localparam logic [2:0] OpVar = 3'd4;

  typedef enum logic [1:0] {StIdle, StDivRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic                 is_var_q, is_var_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     add_res, sub_res;
  logic [WIDTH:0]       rem_shift;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt;

  assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_err    = err_q;
  assign out_ovf    = ovf_q;

  assign sum  = {1'b0, in_op_a} + {1'b0, in_op_b};
  assign diff = {1'b0, in_op_a} - {1'b0, in_op_b};
  assign prod = (2*WIDTH)'(in_op_a) * (2*WIDTH)'(in_op_b);

`ifdef ALU_SAT_EN
  assign add_res = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign sub_res = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
  assign add_res = sum[WIDTH-1:0];
  assign sub_res = diff[WIDTH-1:0];
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A difference that fits is below the divisor, so WIDTH bits of it are exact.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, div_q});
  assign rem_nxt   = rem_ge ? (rem_shift[WIDTH-1:0] - div_q) : rem_shift[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], rem_ge};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    is_var_d = is_var_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone && out_ready) state_d = StIdle;
        if (accept) begin
          state_d  = StDone;
          result_d = '0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          case (in_opc)
            OpAdd: begin
              result_d = {{WIDTH{1'b0}}, add_res};
              ovf_d    = sum[WIDTH];
            end
            OpSub: begin
              result_d = {{WIDTH{1'b0}}, sub_res};
              ovf_d    = diff[WIDTH];
            end
            OpMul: result_d = prod;
            OpDiv, OpVar: begin
              if (in_op_b == '0) begin
                err_d    = 1'b1;
                result_d = (in_opc == OpDiv) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                             : {{WIDTH{1'b0}}, in_op_a};
              end else begin
                state_d  = StDivRun;
                rem_d    = '0;
                quo_d    = in_op_a;
                div_d    = in_op_b;
                is_var_d = (in_opc == OpVar);
                cnt_d    = '0;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StDivRun: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = {{WIDTH{1'b0}}, (is_var_q ? rem_nxt : quo_nxt)};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      is_var_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      is_var_q <= is_var_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
